csr_file_irq: RTL and testbench

Machine-mode CSR file with interrupt arbitration, trap entry/return and retirement counters; parametrised successor of the pipeline's first CSR block. Sits beside the execute/commit stage: serves CSR instructions, decides trap and interrupt redirects, and exports architectural state to difftest. Adds correct RS/RC semantics, minstret, pending-interrupt logic, illegal-access detection and optional vectored mtvec.

---
 rtl/csr_file_irq_pkg.sv | 38 +++
 rtl/csr_file_irq_if.sv | 11 +
 rtl/csr_file_irq_counter.sv | 18 +
 rtl/csr_file_irq.sv | 179 +++++++++++++++++
 tb/tb_csr_file_irq.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_file_irq_pkg.sv
// csr_file_irq_pkg: CSR addresses, cause codes, privilege levels and mstatus layout
// shared by the CSR file, its access interface and its counters.
package csr_file_irq_pkg;
    typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_op_e;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef struct packed {
        logic [1:0] mpp;
        logic       mpie;
        logic       mie;
    } mstatus_t;

    // Only MIE/MPIE/MPP are implemented; all other mstatus bits read as zero.
    function automatic logic [63:0] mstatus_xlen(mstatus_t s);
        return {51'b0, s.mpp, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
    endfunction
endpackage

// File: rtl/csr_file_irq_if.sv
// csr_file_irq_if: CSR instruction access bus between the execute/commit stage and the CSR file.
interface csr_file_irq_if;
    import csr_file_irq_pkg::*;
    csr_op_e     csr_op;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    modport master (output csr_op, csr_addr, csr_wdata, input csr_rdata, csr_illegal);
    modport slave  (input csr_op, csr_addr, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_file_irq_counter.sv
// csr_file_irq_counter: 64-bit wrapping counter with write override and variable increment.
module csr_file_irq_counter #(
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [63:0]   wdata_i,
    input  logic [IW-1:0] inc_i,
    output logic [63:0]   cnt_o
);
    logic [63:0] cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= we_i ? wdata_i : cnt_q + 64'(inc_i);
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_file_irq.sv
// csr_file_irq: machine-mode CSR file with interrupt arbitration, trap entry/return and counters.
// Define CSR_VECTORED_MTVEC_EN to accept mtvec.MODE=1 and vector interrupts to base + 4*cause.
module csr_file_irq
    import csr_file_irq_pkg::*;
#(
    parameter logic [63:0] HART_ID     = 64'h0,
    parameter int          RETIRE_N    = 1,
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    localparam int         RW          = $clog2(RETIRE_N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    csr_file_irq_if.slave csr,
    input  logic [RW-1:0] retire_cnt,
    input  logic          exc_valid,
    input  logic [3:0]    exc_cause,
    input  logic [63:0]   exc_tval,
    input  logic [63:0]   exc_pc,
    input  logic          mret,
    input  logic          irq_msip,
    input  logic          irq_mtip,
    input  logic          irq_meip,
    input  logic          irq_boundary,
    output logic          trap_redirect,
    output logic [63:0]   trap_pc,
    output logic [1:0]    priv_mode,
    output logic [63:0]   mstatus_out,
    output logic [63:0]   mtvec_out,
    output logic [63:0]   mepc_out,
    output logic [63:0]   mcause_out,
    output logic [63:0]   mtval_out,
    output logic [63:0]   mip_out,
    output logic [63:0]   mie_out,
    output logic [63:0]   mscratch_out,
    output logic [63:0]   mcycle_out,
    output logic [63:0]   minstret_out
);
`ifdef CSR_VECTORED_MTVEC_EN
    localparam logic [63:0] MTVEC_WMASK = ~64'h2;
`else
    localparam logic [63:0] MTVEC_WMASK = ~64'h3;
`endif
    mstatus_t    mstatus_q, mstatus_d;
    logic [1:0]  priv_q, priv_d;
    logic [63:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mie_q, mie_d, mscratch_q, mscratch_d, mip_q, mip_d;
    logic [63:0] mcycle, minstret, rdata, wval, base, irq_pc;
    logic [3:0]  irq_code;
    logic        known, wr_req, illegal, csr_we, irq_take, p_mei, p_msi, p_mti;

    always_comb begin
        known = 1'b1;
        rdata = '0;
        case (csr.csr_addr)
            CSR_MSTATUS:  rdata = mstatus_xlen(mstatus_q);
            CSR_MIE:      rdata = mie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MTVAL:    rdata = mtval_q;
            CSR_MIP:      rdata = mip_q;
            CSR_MCYCLE:   rdata = mcycle;
            CSR_MINSTRET: rdata = minstret;
            CSR_MHARTID:  rdata = HART_ID;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            default:      known = 1'b0;
        endcase
    end

    // RS/RC with a zero operand are pure reads, so they stay legal on read-only CSRs.
    assign wr_req  = csr.csr_op == CSR_RW || (csr.csr_op != CSR_NONE && csr.csr_wdata != '0);
    assign illegal = csr.csr_op != CSR_NONE &&
                     (!known || priv_q != PRIV_M || (csr.csr_addr[11:10] == 2'b11 && wr_req));
    assign wval    = csr.csr_op == CSR_RW ? csr.csr_wdata :
                     csr.csr_op == CSR_RS ? rdata | csr.csr_wdata : rdata & ~csr.csr_wdata;
    assign csr.csr_rdata   = rdata;
    assign csr.csr_illegal = illegal;

    assign p_mei    = mip_q[11] & mie_q[11];
    assign p_msi    = mip_q[3] & mie_q[3];
    assign p_mti    = mip_q[7] & mie_q[7];
    assign irq_take = (priv_q != PRIV_M || mstatus_q.mie) && irq_boundary && !exc_valid &&
                      (p_mei || p_msi || p_mti);
    assign irq_code = p_mei ? IRQ_MEI : p_msi ? IRQ_MSI : IRQ_MTI;
    assign csr_we   = wr_req && !illegal && !exc_valid && !irq_take && !mret;
    assign mip_d    = {52'b0, irq_meip, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};

    assign base = {mtvec_q[63:2], 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
    assign irq_pc = mtvec_q[0] ? base + {58'b0, irq_code, 2'b00} : base;
`else
    assign irq_pc = base;
`endif
    assign trap_redirect = reset && (exc_valid || irq_take || mret);
    assign trap_pc = !reset ? '0 : exc_valid ? base : irq_take ? irq_pc : mret ? mepc_q : '0;

    always_comb begin
        mstatus_d  = mstatus_q;
        priv_d     = priv_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mie_d      = mie_q;
        mscratch_d = mscratch_q;
        if (exc_valid || irq_take) begin
            mepc_d         = exc_pc;
            mcause_d       = exc_valid ? {60'b0, exc_cause} : {1'b1, 59'b0, irq_code};
            mtval_d        = exc_valid ? exc_tval : '0;
            mstatus_d.mpie = mstatus_q.mie;
            mstatus_d.mie  = 1'b0;
            mstatus_d.mpp  = priv_q;
            priv_d         = PRIV_M;
        end else if (mret) begin
            mstatus_d.mie  = mstatus_q.mpie;
            mstatus_d.mpie = 1'b1;
            mstatus_d.mpp  = PRIV_U;
            priv_d         = mstatus_q.mpp;
        end else if (csr_we) begin
            case (csr.csr_addr)
                CSR_MSTATUS:  mstatus_d = '{mpp: wval[12:11] == PRIV_M ? PRIV_M : PRIV_U,
                                            mpie: wval[7], mie: wval[3]};
                CSR_MTVEC:    mtvec_d = wval & MTVEC_WMASK;
                CSR_MEPC:     mepc_d = wval;
                CSR_MCAUSE:   mcause_d = wval;
                CSR_MTVAL:    mtval_d = wval;
                CSR_MIE:      mie_d = wval;
                CSR_MSCRATCH: mscratch_d = wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_q  <= '0;
            priv_q     <= PRIV_M;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mie_q      <= '0;
            mscratch_q <= '0;
            mip_q      <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            priv_q     <= priv_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mie_q      <= mie_d;
            mscratch_q <= mscratch_d;
            mip_q      <= mip_d;
        end
    end

    csr_file_irq_counter #(.IW(1)) u_mcycle (
        .clk, .reset, .we_i(csr_we && csr.csr_addr == CSR_MCYCLE), .wdata_i(wval),
        .inc_i(1'b1), .cnt_o(mcycle)
    );
    csr_file_irq_counter #(.IW(RW)) u_minstret (
        .clk, .reset, .we_i(csr_we && csr.csr_addr == CSR_MINSTRET), .wdata_i(wval),
        .inc_i(retire_cnt), .cnt_o(minstret)
    );

    assign priv_mode    = priv_q;
    assign mstatus_out  = mstatus_xlen(mstatus_q);
    assign mtvec_out    = mtvec_q;
    assign mepc_out     = mepc_q;
    assign mcause_out   = mcause_q;
    assign mtval_out    = mtval_q;
    assign mip_out      = mip_q;
    assign mie_out      = mie_q;
    assign mscratch_out = mscratch_q;
    assign mcycle_out   = mcycle;
    assign minstret_out = minstret;
endmodule

// File: tb/tb_csr_file_irq.sv
// tb_csr_file_irq: randomized and directed checks of csr_file_irq against a CSR-map reference model.
module tb_csr_file_irq;
    import csr_file_irq_pkg::*;
    localparam logic [63:0] HID = 64'h5;
    localparam logic [63:0] MTR = 64'h8000_0100;
`ifdef CSR_VECTORED_MTVEC_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif
    localparam int A_MSTATUS = 'h300, A_MIE = 'h304, A_MTVEC = 'h305, A_MEPC = 'h341;
    localparam int A_MCAUSE = 'h342, A_MTVAL = 'h343, A_MIP = 'h344, A_MSCRATCH = 'h340;
    localparam int A_MCYCLE = 'hB00, A_MINSTRET = 'hB02, A_MHARTID = 'hF14;

    logic clk = 1'b0, reset = 1'b0;
    logic [1:0] op, retire;
    logic [11:0] addr;
    logic [63:0] wd, tval, pc;
    logic exc_valid, mret, msip, mtip, meip, boundary;
    logic [3:0] cause;
    logic trap_redirect;
    logic [1:0] priv_mode;
    logic [63:0] trap_pc, mstatus_out, mtvec_out, mepc_out, mcause_out, mtval_out, mip_out;
    logic [63:0] mie_out, mscratch_out, mcycle_out, minstret_out;
    int checks = 0, failures = 0;
    logic [63:0] m [int];
    logic [1:0] mpriv;
    int known_a [13] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 'hB00,
                         'hB02, 'hF11, 'hF12, 'hF13};
    int pick_a [15] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 'hB00,
                        'hB02, 'hF11, 'hF12, 'hF13, 'hF14, 'h7C0};

    csr_file_irq_if bus ();
    assign bus.csr_op = csr_op_e'(op);
    assign bus.csr_addr = addr;
    assign bus.csr_wdata = wd;

    csr_file_irq #(.HART_ID(HID), .RETIRE_N(2), .MTVEC_RESET(MTR)) dut (
        .clk(clk), .reset(reset), .csr(bus), .retire_cnt(retire), .exc_valid(exc_valid),
        .exc_cause(cause), .exc_tval(tval), .exc_pc(pc), .mret(mret), .irq_msip(msip),
        .irq_mtip(mtip), .irq_meip(meip), .irq_boundary(boundary),
        .trap_redirect(trap_redirect), .trap_pc(trap_pc), .priv_mode(priv_mode),
        .mstatus_out(mstatus_out), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
        .mcause_out(mcause_out), .mtval_out(mtval_out), .mip_out(mip_out), .mie_out(mie_out),
        .mscratch_out(mscratch_out), .mcycle_out(mcycle_out), .minstret_out(minstret_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        op = 0; addr = 0; wd = 0; retire = 0; exc_valid = 0; cause = 0; tval = 0; pc = 0;
        mret = 0; msip = 0; mtip = 0; meip = 0; boundary = 0;
    endtask

    task automatic set(input int o, input int a, input logic [63:0] w);
        op = 2'(o); addr = 12'(a); wd = w;
    endtask

    task automatic model_reset();
        m.delete();
        foreach (known_a[i]) m[known_a[i]] = '0;
        m[A_MTVEC] = MTR;
        m[A_MHARTID] = HID;
        mpriv = 2'd3;
    endtask

    // Predict combinational outputs from the CSR map, compare everything, then advance the map one edge.
    task automatic step();
        logic [63:0] rd, nv, st, base, tpc, pend, mt;
        logic known, wr, ill, tirq, red;
        int a, code;
        #1;
        a = int'(addr);
        known = m.exists(a);
        rd = known ? m[a] : 64'h0;
        wr = op == 2'd1 || (op != 2'd0 && wd != 64'h0);
        ill = op != 2'd0 && (!known || mpriv != 2'd3 || (a >= 'hC00 && wr));
        st = m[A_MSTATUS];
        mt = m[A_MTVEC];
        pend = m[A_MIP] & m[A_MIE];
        tirq = !exc_valid && boundary && (mpriv != 2'd3 || st[3]) && (pend & 64'h888) != 0;
        code = pend[11] ? 11 : pend[3] ? 3 : 7;
        base = mt & ~64'h3;
        red = exc_valid || tirq || mret;
        tpc = exc_valid ? base : tirq ? base + ((VEC && mt[0]) ? 64'(4 * code) : 64'h0) :
              mret ? m[A_MEPC] : 64'h0;
        chk("rdata", bus.csr_rdata, rd);
        chk("illegal", bus.csr_illegal, ill);
        chk("redirect", trap_redirect, red);
        chk("trap_pc", trap_pc, tpc);
        chk("priv", priv_mode, mpriv);
        chk("mstatus", mstatus_out, st);
        chk("mtvec", mtvec_out, mt);
        chk("mepc", mepc_out, m[A_MEPC]);
        chk("mcause", mcause_out, m[A_MCAUSE]);
        chk("mtval", mtval_out, m[A_MTVAL]);
        chk("mip", mip_out, m[A_MIP]);
        chk("mie", mie_out, m[A_MIE]);
        chk("mscratch", mscratch_out, m[A_MSCRATCH]);
        chk("mcycle", mcycle_out, m[A_MCYCLE]);
        chk("minstret", minstret_out, m[A_MINSTRET]);
        m[A_MCYCLE] = m[A_MCYCLE] + 64'h1;
        m[A_MINSTRET] = m[A_MINSTRET] + 64'(retire);
        if (exc_valid || tirq) begin
            m[A_MEPC] = pc;
            m[A_MCAUSE] = exc_valid ? 64'(cause) : (64'h1 << 63) | 64'(code);
            m[A_MTVAL] = exc_valid ? tval : 64'h0;
            st[7] = st[3];
            st[3] = 1'b0;
            st[12:11] = mpriv;
            mpriv = 2'd3;
        end else if (mret) begin
            mpriv = st[12:11];
            st[3] = st[7];
            st[7] = 1'b1;
            st[12:11] = 2'd0;
        end else if (wr && !ill) begin
            nv = op == 2'd1 ? wd : op == 2'd2 ? rd | wd : rd & ~wd;
            if (a == A_MSTATUS) begin
                st = nv & 64'h1888;
                if (st[12:11] == 2'd1 || st[12:11] == 2'd2) st[12:11] = 2'd0;
            end else if (a == A_MTVEC) m[a] = nv & ~(VEC ? 64'h2 : 64'h3);
            else if (a != A_MIP) m[a] = nv;
        end
        m[A_MSTATUS] = st;
        m[A_MIP] = (64'(meip) << 11) | (64'(mtip) << 7) | (64'(msip) << 3);
        @(negedge clk);
    endtask

    task automatic rand_in();
        op = 2'($urandom % 4);
        addr = 12'(pick_a[$urandom % 15]);
        case ($urandom % 4)
            0: wd = 64'h0;
            1: wd = 64'h8;
            2: wd = {$urandom, $urandom};
            default: wd = 64'h1888;
        endcase
        exc_valid = ($urandom % 10) == 0;
        cause = 4'($urandom);
        tval = {$urandom, $urandom};
        pc = {$urandom, $urandom};
        mret = ($urandom % 10) == 0;
        msip = ($urandom % 4) == 0;
        mtip = ($urandom % 4) == 0;
        meip = ($urandom % 4) == 0;
        boundary = 1'($urandom);
        retire = 2'($urandom % 3);
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();
        chk("rst_mtvec", mtvec_out, MTR);
        chk("rst_priv", priv_mode, 2'd3);
        set(1, A_MSTATUS, 64'h1880); step();
        set(2, A_MSTATUS, 64'h8); step();
        chk("rs_mie", mstatus_out, 64'h1888);
        set(3, A_MSTATUS, 64'h8); step();
        chk("rc_mie", mstatus_out, 64'h1880);
        set(1, A_MIE, 64'h80); step();
        set(2, A_MSTATUS, 64'h8); step();
        idle(); mtip = 1; step();
        boundary = 1; pc = 64'h1234; step();
        chk("mti_cause", mcause_out, 64'h8000_0000_0000_0007);
        chk("mti_mie_mpie", mstatus_out & 64'h88, 64'h80);
        idle(); mret = 1; step();
        idle(); set(1, A_MIE, 64'h800); step();
        idle(); meip = 1; step();
        exc_valid = 1; cause = 4'd2; pc = 64'h2000; tval = 64'hbad; boundary = 1; step();
        chk("exc_cause", mcause_out, 64'h2);
        chk("exc_mepc", mepc_out, 64'h2000);
        idle(); meip = 1; mret = 1; step();
        mret = 0; boundary = 1; pc = 64'h3000; step();
        chk("mei_cause", mcause_out, 64'h8000_0000_0000_000B);
        idle(); set(1, A_MTVEC, MTR | 64'h1); step();
        idle(); mret = 1; step();
        idle(); meip = 1; step();
        boundary = 1; pc = 64'h4000;
        #1 chk("vec_pc", trap_pc, VEC ? MTR + 64'd44 : MTR);
        step();
        idle(); set(1, A_MHARTID, 64'h77);
        #1 chk("hartid_rw_ill", bus.csr_illegal, 1'b1);
        step();
        chk("hartid_kept", mepc_out, 64'h4000);
        set(2, A_MHARTID, 64'h0);
        #1 chk("hartid_rs0_ill", bus.csr_illegal, 1'b0);
        chk("hartid_rd", bus.csr_rdata, HID);
        step();
        idle(); set(1, A_MINSTRET, 64'h0); step();
        idle(); retire = 2'd2;
        repeat (5) step();
        chk("minstret10", minstret_out, 64'd10);
        repeat (400) begin
            rand_in();
            step();
        end
        idle(); exc_valid = 1; step();
        idle(); set(1, A_MCYCLE, 64'd99); step();
        idle(); step();
        chk("mcycle100", mcycle_out, 64'd100);
        reset = 1'b0; exc_valid = 1; mret = 1;
        #1;
        model_reset();
        chk("arst_mcycle", mcycle_out, 64'h0);
        chk("arst_priv", priv_mode, 2'd3);
        chk("arst_mtvec", mtvec_out, MTR);
        chk("arst_redirect", trap_redirect, 1'b0);
        chk("arst_trap_pc", trap_pc, 64'h0);
        @(negedge clk);
        chk("arst_hold", mcycle_out, 64'h0);
        reset = 1'b1;
        idle();
        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
